// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 active-low matrix keypad scanner with row synchroniser and frame-level debounce.
// Optional build macro KEYPAD_GHOST_REJECT_EN: frames with two or more pressed keys read as released.
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key,
  output logic       key_strobe
);

  localparam logic [4:0] KEY_NONE = 5'd31;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] S_COL0 = 2'd0;
  localparam logic [1:0] S_COL1 = 2'd1;
  localparam logic [1:0] S_COL2 = 2'd2;
  localparam logic [1:0] S_COL3 = 2'd3;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [4:0]       frame_code;
  logic [4:0]       prev_code;
  logic [3:0]       stable_cnt;
  logic [3:0]       stable_next;
  logic [4:0]       col_code;
  logic [4:0]       merged_code;
  logic [4:0]       eval_code;
  logic             sample;
  logic             frame_end;

  function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'h0: code = 5'd1;   4'h1: code = 5'd2;   4'h2: code = 5'd3;   4'h3: code = 5'd10;
      4'h4: code = 5'd4;   4'h5: code = 5'd5;   4'h6: code = 5'd6;   4'h7: code = 5'd11;
      4'h8: code = 5'd7;   4'h9: code = 5'd8;   4'hA: code = 5'd9;   4'hB: code = 5'd12;
      4'hC: code = 5'd14;  4'hD: code = 5'd0;   4'hE: code = 5'd15;  default: code = 5'd13;
    endcase
    return code;
  endfunction

  always_comb begin
    case (state_reg)
      S_COL0:  col = 4'b1110;
      S_COL1:  col = 4'b1101;
      S_COL2:  col = 4'b1011;
      default: col = 4'b0111;
    endcase
  end

  always_comb begin
    case (state_reg)
      S_COL0:  state_next = S_COL1;
      S_COL1:  state_next = S_COL2;
      S_COL2:  state_next = S_COL3;
      default: state_next = S_COL0;
    endcase
  end

  assign sample    = (div_cnt == DIV_LAST);
  assign frame_end = sample && (state_reg == S_COL3);

  // Walk rows from the bottom up so the lowest pressed row wins within the column.
  always_comb begin
    col_code = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) col_code = key_map(2'(r), state_reg);
    end
  end

  assign merged_code = (frame_code != KEY_NONE) ? frame_code : col_code;

`ifdef KEYPAD_GHOST_REJECT_EN
  logic [1:0] frame_cnt;
  logic [2:0] col_hits;
  logic [2:0] cnt_sum;
  logic [1:0] merged_cnt;

  always_comb begin
    col_hits = 3'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) col_hits = col_hits + 3'd1;
    end
    cnt_sum    = col_hits + {1'b0, frame_cnt};
    merged_cnt = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
  end

  assign eval_code = (merged_cnt >= 2'd2) ? KEY_NONE : merged_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 2'd0;
    end else if (frame_end) begin
      frame_cnt <= 2'd0;
    end else if (sample) begin
      frame_cnt <= merged_cnt;
    end
  end
`else
  assign eval_code = merged_code;
`endif

  always_comb begin
    if (eval_code == prev_code) begin
      stable_next = (stable_cnt >= DEB_MAX) ? DEB_MAX : stable_cnt + 4'd1;
    end else begin
      stable_next = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_COL0;
      div_cnt    <= '0;
      frame_code <= KEY_NONE;
      prev_code  <= KEY_NONE;
      stable_cnt <= 4'd0;
      key        <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (sample) begin
        div_cnt   <= '0;
        state_reg <= state_next;
        if (frame_end) begin
          frame_code <= KEY_NONE;
          prev_code  <= eval_code;
          stable_cnt <= stable_next;
          // key only moves here, once per frame, so downstream sees a clean level.
          if ((stable_next == DEB_MAX) && (eval_code != key)) begin
            key        <= eval_code;
            key_strobe <= (eval_code != KEY_NONE);
          end
        end else begin
          frame_code <= merged_code;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Directed bench for keypad_scanner: a frame-level keypad model predicts col, key and
// key_strobe every cycle; literal checks pin the model at the scenario milestones.
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] key;
  logic       key_strobe;

  logic [15:0] pressed = 16'h0000;   // bit r*4+c set = key at row r, column c held down

  int checks     = 0;
  int failures   = 0;
  int strobe_cnt = 0;

  int key_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key(key), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key shorts its row to the driven-low column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_value(input logic [15:0] p);
    int first = 31;
    int cnt = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (p[r*4+c]) begin
          if (first == 31) first = key_tab[r][c];
          cnt++;
        end
`ifdef KEYPAD_GHOST_REJECT_EN
    if (cnt >= 2) first = 31;
`endif
    return first;
  endfunction

  // Model: cycles since reset release, history of frame results, expected outputs.
  int n = 0;
  int m_key = 31;
  int m_strobe = 0;
  int nfr = 0;
  int hist[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        n++;
        m_strobe = 0;
        if (n % FRAME == 0) begin
          int f;
          bit same;
          f = frame_value(pressed);
          hist.push_front(f);
          if (hist.size() > DEB) void'(hist.pop_back());
          nfr++;
          same = 1'b1;
          foreach (hist[i]) if (hist[i] != f) same = 1'b0;
          if (nfr >= DEB && same && f != m_key) begin
            m_key = f;
            m_strobe = (f != 31) ? 1 : 0;
          end
        end
      end
      @(negedge clk);
      if (rst) begin
        n = 0; m_key = 31; m_strobe = 0; nfr = 0; hist.delete();
      end
      check("col", int'(col), int'(~(4'b0001 << ((n / CLK_DIV) % 4)) & 4'hF));
      check("key", int'(key), m_key);
      check("key_strobe", int'(key_strobe), m_strobe);
      if (key_strobe) strobe_cnt++;
    end
  end

  task automatic run_frames(input logic [15:0] p, input int nf);
    pressed = p;
    repeat (FRAME * nf) @(posedge clk);
    #1;
    $display("frames=%0d pressed=%h key=%0d strobe=%0d", nf, p, key, key_strobe);
  endtask

  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K9  = 16'h0400;
  localparam logic [15:0] K12 = 16'h0003;

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Reset mid-frame, idle rows.
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_col", int'(col), 4'b1110);
    check("rst_key", int'(key), 31);
    check("rst_strobe", int'(key_strobe), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("walk_col1", int'(col), 4'b1101);
    repeat (4) @(posedge clk);
    #1 check("walk_col2", int'(col), 4'b1011);
    repeat (8) @(posedge clk);
    #1;

    // Single press of key 5.
    s0 = strobe_cnt;
    run_frames(K5, 2);
    check("press5_f2", int'(key), 31);
    run_frames(K5, 1);
    check("press5_f3", int'(key), 5);
    check("press5_strobe", int'(key_strobe), 1);
    run_frames(K5, 2);
    check("press5_hold", int'(key), 5);
    check("press5_nstrobe", strobe_cnt - s0, 1);

    // Release.
    s0 = strobe_cnt;
    run_frames(16'h0, 2);
    check("rel_f2", int'(key), 5);
    run_frames(16'h0, 1);
    check("rel_f3", int'(key), 31);
    run_frames(16'h0, 1);
    check("rel_nstrobe", strobe_cnt - s0, 0);

    // Bounce: pressed, pressed, released, then pressed.
    run_frames(K5, 2);
    run_frames(16'h0, 1);
    run_frames(K5, 1);
    check("bounce_f4", int'(key), 31);
    run_frames(K5, 1);
    check("bounce_f5", int'(key), 31);
    run_frames(K5, 1);
    check("bounce_f6", int'(key), 5);
    run_frames(16'h0, 3);
    check("bounce_rel", int'(key), 31);

    // Keys 1 and 2 together.
    run_frames(K12, 3);
`ifdef KEYPAD_GHOST_REJECT_EN
    check("two_keys", int'(key), 31);
`else
    check("two_keys", int'(key), 1);
`endif
    run_frames(16'h0, 3);
    check("two_rel", int'(key), 31);

    // Reset while key 9 is held.
    run_frames(K9, 3);
    check("hold9", int'(key), 9);
    run_frames(K9, 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst9_key", int'(key), 31);
    @(posedge clk);
    #1 rst = 1'b0;
    s0 = strobe_cnt;
    run_frames(K9, 2);
    check("rst9_f2", int'(key), 31);
    run_frames(K9, 1);
    check("rst9_f3", int'(key), 9);
    run_frames(K9, 1);
    check("rst9_nstrobe", strobe_cnt - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×4 active-low matrix keypad, synchronises and debounces the row inputs, and presents one 5-bit key code on `key`. The code is held for as long as the key stays pressed. The block sits directly upstream of the calculator control state machine. That state machine uses the level of `key` (`KEY_NONE` versus a code) for its press/release handshake, so `key` is a clean, glitch-free level that changes at most once per scan frame.

## Interface
Parameters:
- `CLK_DIV`, default 1000: clk cycles each column is driven. Legal minimum is 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frames required before `key` changes. Legal range is 1 to 15.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `row`  in  4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out  4: column drive, active-low, exactly one bit low at all times.
- `key`  out  5: debounced key code. 0–9 = `KEY_0`..`KEY_9`, 10–15 = `KEY_A`..`KEY_F`, 31 = `KEY_NONE`.
- `key_strobe`  out  1: one-cycle pulse when `key` changes to a code other than `KEY_NONE`.

## Operation
- Key map (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Row synchroniser:
  - `row` passes through a 2-flop synchroniser before any use.
  - A row bit reading 0 means pressed.
- Scan FSM: states `S_COL0`, `S_COL1`, `S_COL2`, `S_COL3`, cycling in that order.
  - State `S_COLc` drives `col[c]`=0 and all other column bits to 1.
  - `div_cnt` counts 0..`CLK_DIV`-1 within each state.
  - The state advances when `div_cnt` == `CLK_DIV`-1. `S_COL3` wraps to `S_COL0`.
- Sampling:
  - Synchronised rows are sampled on the cycle where `div_cnt` == `CLK_DIV`-1. At that point the column has been driven for at least 3 settled cycles.
  - Sampling accumulates into two frame registers:
    - `frame_code`: the first pressed key in scan order (column 0→3, within a column row 0→3). Initialised to `KEY_NONE` at frame start.
    - `frame_cnt`: number of pressed keys in the frame, saturating at 2.
- Frame evaluation happens on the `S_COL3` sample cycle, using that column's sample merged in. Call the merged result `F`.
  - If `F` == `prev_code`: `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
  - Otherwise: `stable_cnt` ← 1 and `prev_code` ← `F`.
  - If the resulting `stable_cnt` == `DEBOUNCE_SCANS` and `F` != `key`: `key` ← `F`, registered on that edge.
  - `key_strobe` is 1 for the following cycle only, and only when `F` != `KEY_NONE`.
- Properties of `key`:
  - Never changes outside frame evaluation.
  - Never takes any value other than 0–15 or 31.
- Release: `KEY_NONE` is debounced exactly like a code and needs `DEBOUNCE_SCANS` identical frames. Release raises no strobe.
- Direct key-to-key change (for example 5 → 6 with no clean release): `key` moves straight to the new code, and `key_strobe` pulses.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = `S_COL0`, `col` = 4'b1110.
  - `div_cnt` = 0.
  - `key` = 31, `key_strobe` = 0.
  - `prev_code` = 31, `stable_cnt` = 0, `frame_code` = 31, `frame_cnt` = 0.
  - Synchroniser flops = 4'b1111.
- Frame length: 4·`CLK_DIV` cycles.
- Press latency:
  - A press is stable on the pins before a frame starts: `key` updates at the end of frame `DEBOUNCE_SCANS`.
  - Worst case: `DEBOUNCE_SCANS`+1 frames plus 2 cycles.
- Any bounce that changes `F` restarts the count at 1.
- Reset mid-frame: the partial frame and all debounce state are discarded. A held key needs a full `DEBOUNCE_SCANS` frames again after reset.
- `key_strobe` never asserts in consecutive cycles. Its minimum spacing is `DEBOUNCE_SCANS` frames.

## Configuration
- Macro `KEYPAD_GHOST_REJECT_EN`.
  - Defined: at frame evaluation, `frame_cnt` ≥ 2 forces `F` = `KEY_NONE`. Multi-key and ghosted presses therefore read as released.
  - Undefined: `frame_cnt` is not built, and `F` is the first pressed key in scan order.

## Test plan
All scenarios use `CLK_DIV`=4 and `DEBOUNCE_SCANS`=3.
- Reset:
  - Stimulus: assert `rst` mid-frame with `row`=4'b1111.
  - Required: `col`=1110, `key`=31 and `key_strobe`=0 immediately. Then `col` walks 1110→1101→1011→0111 every 4 cycles.
- Single press, key 5:
  - Stimulus: row1 low whenever `col`=1101, held for 5 frames.
  - Required: `key`=5 at the end of the 3rd full frame, with exactly one `key_strobe` pulse. `key` stays 5 afterwards.
- Bounce:
  - Stimulus: key 5 pressed in frames 1, 2 and 4, released in frame 3.
  - Required: `key` stays 31 through frame 4 and becomes 5 only after frame 6.
- Release:
  - Stimulus: starting from `key`=5, release all rows.
  - Required: `key`=31 after 3 frames, with no `key_strobe`.
- Two keys, 1 (r0,c0) and 2 (r0,c1), pressed together:
  - With `KEYPAD_GHOST_REJECT_EN`: `key` stays 31.
  - Without it: `key`=1 after 3 frames.
- Reset during a held key 9:
  - Stimulus: pulse `rst` while key 9 is held.
  - Required: `key`=31 at once, then 9 again 3 full frames after `rst` falls, with one `key_strobe`.
